// File: rtl/port_egress_sink_if.sv
// Bundle between the switch egress port, the packet consumer and
// the statistics readout of port_egress_sink.
interface port_egress_sink_if #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             sw_valid;
    logic [3:0]       sw_source;
    logic [3:0]       sw_target;
    logic [7:0]       sw_data;
    logic             pkt_valid;
    logic             pkt_ready;
    logic [3:0]       pkt_source;
    logic [7:0]       pkt_data;
    logic [LW-1:0]    fifo_level;
    logic [CNT_W-1:0] rx_count;
    logic [CNT_W-1:0] drop_count;
    logic [CNT_W-1:0] misroute_count;
    logic             overflow;
    logic             clear_stats;

    modport master (
        output sw_valid, sw_source, sw_target, sw_data,
        output pkt_ready, clear_stats,
        input  pkt_valid, pkt_source, pkt_data, fifo_level,
        input  rx_count, drop_count, misroute_count, overflow
    );

    modport slave (
        input  sw_valid, sw_source, sw_target, sw_data,
        input  pkt_ready, clear_stats,
        output pkt_valid, pkt_source, pkt_data, fifo_level,
        output rx_count, drop_count, misroute_count, overflow
    );
endinterface

// File: rtl/port_egress_sink.sv
// Egress sink: FWFT packet FIFO plus saturating rx/drop/misroute stats.
// Define MISROUTE_CHECK_EN to reject packets not targeting PORT_ID.
module port_egress_sink #(
    parameter int PORT_ID = 1,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 16
) (
    input logic                clk,
    input logic                rst_n,
    port_egress_sink_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef logic [CNT_W-1:0] cnt_t;

    logic [3:0]    src_mem [DEPTH];
    logic [7:0]    dat_mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    cnt_t          rx_q, rx_d;
    cnt_t          drop_q, drop_d;
    logic          ovf_q, ovf_d;

    logic          misroute;
    logic          head_valid;
    logic          full;
    logic          pop;
    logic          drop;
    logic          push;

    function automatic cnt_t sat_inc(cnt_t v);
        return (&v) ? v : v + cnt_t'(1);
    endfunction

`ifdef MISROUTE_CHECK_EN
    cnt_t mis_q, mis_d;

    assign misroute = bus.sw_valid & ~bus.sw_target[PORT_ID];

    // Misroute counter next state; a clear suppresses the same-cycle event.
    always_comb begin
        mis_d = mis_q;
        if (bus.clear_stats) begin
            mis_d = '0;
        end else if (misroute) begin
            mis_d = sat_inc(mis_q);
        end
    end

    // Misroute counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_q <= '0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign bus.misroute_count = mis_q;
`else
    logic unused_target;

    assign unused_target      = ^bus.sw_target;
    assign misroute           = 1'b0;
    assign bus.misroute_count = '0;
`endif

    assign head_valid = (level_q != '0);
    assign full       = (level_q == LW'(DEPTH));
    assign pop        = head_valid & bus.pkt_ready;
    assign drop       = bus.sw_valid & ~misroute & full & ~pop;
    assign push       = bus.sw_valid & ~misroute & ~drop;

    // Pointer and occupancy next state; pointers wrap modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Receive/drop statistics; a clear wins over a same-cycle event.
    always_comb begin
        rx_d   = rx_q;
        drop_d = drop_q;
        ovf_d  = ovf_q;
        if (bus.clear_stats) begin
            rx_d   = '0;
            drop_d = '0;
            ovf_d  = 1'b0;
        end else begin
            if (push) begin
                rx_d = sat_inc(rx_q);
            end
            if (drop) begin
                drop_d = sat_inc(drop_q);
                ovf_d  = 1'b1;
            end
        end
    end

    // Control state; reset empties the FIFO without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rx_q     <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rx_q     <= rx_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
        end
    end

    // Payload storage; contents are only meaningful below the level.
    always_ff @(posedge clk) begin
        if (push) begin
            src_mem[wr_ptr_q] <= bus.sw_source;
            dat_mem[wr_ptr_q] <= bus.sw_data;
        end
    end

    assign bus.pkt_valid  = head_valid;
    assign bus.pkt_source = head_valid ? src_mem[rd_ptr_q] : 4'd0;
    assign bus.pkt_data   = head_valid ? dat_mem[rd_ptr_q] : 8'd0;
    assign bus.fifo_level = level_q;
    assign bus.rx_count   = rx_q;
    assign bus.drop_count = drop_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_port_egress_sink.sv
// Directed bench for port_egress_sink with a scoreboard queue
// and a small reference model of level and statistics.
module tb_port_egress_sink;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    typedef struct packed {
        logic [3:0] src;
        logic [7:0] dat;
    } pkt_t;

    pkt_t sb[$];
    int   m_level;
    int   m_rx;
    int   m_drop;
    int   m_mis;
    int   m_ovf;

    port_egress_sink_if #(.DEPTH(8), .CNT_W(16)) bus ();

    port_egress_sink #(
        .PORT_ID(1),
        .DEPTH  (8),
        .CNT_W  (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_level = 0;
        m_rx    = 0;
        m_drop  = 0;
        m_mis   = 0;
        m_ovf   = 0;
    endtask

    // One clock with current inputs; checks head and post-edge state.
    task automatic step();
        logic mis, pp, dr, pu;
        pkt_t p;
        mis = 1'b0;
`ifdef MISROUTE_CHECK_EN
        mis = bus.sw_valid && !bus.sw_target[1];
`endif
        pp = (m_level != 0) && bus.pkt_ready;
        dr = bus.sw_valid && !mis && (m_level == 8) && !pp;
        pu = bus.sw_valid && !mis && !dr;
        chk("pkt_valid", {31'd0, bus.pkt_valid}, {31'd0, m_level != 0});
        if (pp && sb.size() > 0) begin
            p = sb.pop_front();
            chk("head_data", {24'd0, bus.pkt_data}, {24'd0, p.dat});
            chk("head_src", {28'd0, bus.pkt_source}, {28'd0, p.src});
        end
        if (pu) begin
            sb.push_back({bus.sw_source, bus.sw_data});
        end
        if (bus.clear_stats) begin
            m_rx   = 0;
            m_drop = 0;
            m_mis  = 0;
            m_ovf  = 0;
        end else begin
            if (pu && m_rx != 65535) m_rx++;
            if (dr && m_drop != 65535) m_drop++;
            if (dr) m_ovf = 1;
            if (mis && m_mis != 65535) m_mis++;
        end
        m_level = m_level + int'(pu) - int'(pp);
        @(posedge clk);
        #1;
        chk("fifo_level", 32'(bus.fifo_level), m_level);
        chk("rx_count", 32'(bus.rx_count), m_rx);
        chk("drop_count", 32'(bus.drop_count), m_drop);
        chk("misroute_count", 32'(bus.misroute_count), m_mis);
        chk("overflow", {31'd0, bus.overflow}, m_ovf);
    endtask

    task automatic send(logic [3:0] s, logic [3:0] t, logic [7:0] d);
        bus.sw_valid  = 1'b1;
        bus.sw_source = s;
        bus.sw_target = t;
        bus.sw_data   = d;
        step();
        bus.sw_valid  = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        errors          = 0;
        checks          = 0;
        rst_n           = 1'b0;
        bus.sw_valid    = 1'b0;
        bus.sw_source   = 4'd0;
        bus.sw_target   = 4'd0;
        bus.sw_data     = 8'd0;
        bus.pkt_ready   = 1'b0;
        bus.clear_stats = 1'b0;
        model_reset();
        #12;
        chk("rst_pkt_valid", {31'd0, bus.pkt_valid}, 0);
        chk("rst_pkt_source", {28'd0, bus.pkt_source}, 0);
        chk("rst_pkt_data", {24'd0, bus.pkt_data}, 0);
        chk("rst_level", 32'(bus.fifo_level), 0);
        chk("rst_rx", 32'(bus.rx_count), 0);
        chk("rst_drop", 32'(bus.drop_count), 0);
        chk("rst_ovf", {31'd0, bus.overflow}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single packet with consumer always ready.
        bus.pkt_ready = 1'b1;
        send(4'b0001, 4'b0010, 8'hAA);
        chk("single_valid", {31'd0, bus.pkt_valid}, 1);
        chk("single_data", {24'd0, bus.pkt_data}, 32'hAA);
        chk("single_src", {28'd0, bus.pkt_source}, 32'h1);
        chk("single_rx", 32'(bus.rx_count), 1);
        idle(2);
        chk("single_gone", {31'd0, bus.pkt_valid}, 0);

        // Overflow: ten packets into eight entries.
        bus.pkt_ready = 1'b0;
        for (int i = 0; i < 10; i++) send(4'b0001, 4'b0010, 8'(i));
        chk("ovf_level", 32'(bus.fifo_level), 8);
        chk("ovf_drop", 32'(bus.drop_count), 2);
        chk("ovf_flag", {31'd0, bus.overflow}, 1);
        chk("ovf_head", {24'd0, bus.pkt_data}, 0);
        idle(2);
        chk("hold_head", {24'd0, bus.pkt_data}, 0);
        bus.pkt_ready = 1'b1;
        idle(8);
        chk("drain_empty", {31'd0, bus.pkt_valid}, 0);

        // Full FIFO with simultaneous push and pop.
        bus.pkt_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(4'b0100, 4'b0010, 8'(8'h10 + i));
        bus.pkt_ready = 1'b1;
        send(4'b1000, 4'b0010, 8'h55);
        chk("pp_level", 32'(bus.fifo_level), 8);
        chk("pp_drop", 32'(bus.drop_count), 2);
        idle(7);
        chk("pp_last_data", {24'd0, bus.pkt_data}, 32'h55);
        chk("pp_last_src", {28'd0, bus.pkt_source}, 32'h8);
        idle(1);
        chk("pp_empty", 32'(bus.fifo_level), 0);

        // Target check: other-port target, then multicast including us.
        bus.pkt_ready = 1'b0;
        send(4'b0010, 4'b0100, 8'h66);
`ifdef MISROUTE_CHECK_EN
        chk("mis_count", 32'(bus.misroute_count), 1);
        chk("mis_level", 32'(bus.fifo_level), 0);
`else
        chk("mis_count", 32'(bus.misroute_count), 0);
        chk("mis_level", 32'(bus.fifo_level), 1);
`endif
        send(4'b0010, 4'b0110, 8'h77);
        bus.pkt_ready = 1'b1;
        idle(3);
        chk("mis_drained", {31'd0, bus.pkt_valid}, 0);

        // Clear in the same cycle as a packet.
        bus.pkt_ready   = 1'b0;
        bus.clear_stats = 1'b1;
        send(4'b0001, 4'b1010, 8'hC3);
        bus.clear_stats = 1'b0;
        chk("clr_rx", 32'(bus.rx_count), 0);
        chk("clr_drop", 32'(bus.drop_count), 0);
        chk("clr_ovf", {31'd0, bus.overflow}, 0);
        chk("clr_level", 32'(bus.fifo_level), 1);
        chk("clr_data", {24'd0, bus.pkt_data}, 32'hC3);
        send(4'b0001, 4'b0010, 8'h3C);
        chk("post_clr_rx", 32'(bus.rx_count), 1);

        // Reset mid-burst: queue one more, then assert reset off-edge.
        send(4'b0001, 4'b0010, 8'h5A);
        chk("pre_rst_level", 32'(bus.fifo_level), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, bus.pkt_valid}, 0);
        chk("async_rst_level", 32'(bus.fifo_level), 0);
        chk("async_rst_rx", 32'(bus.rx_count), 0);
        model_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Traffic after reset with ready asserted throughout.
        bus.pkt_ready = 1'b1;
        send(4'b0100, 4'b0010, 8'hE1);
        send(4'b1000, 4'b1111, 8'hE2);
        idle(3);
        chk("final_empty", {31'd0, bus.pkt_valid}, 0);
        chk("final_sb", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/port_egress_sink.md
# port_egress_sink

Egress-side receiver for one port of `switch_4port`. It captures every packet the switch presents on a port's output (`valid_out`, `source_out`, `target_out`, `data_out`) and buffers it in a first-word-fall-through FIFO. It hands packets to a downstream consumer over a valid/ready handshake and keeps saturating receive, drop and misroute statistics. The switch output has no backpressure, so this block absorbs bursts and accounts for every packet it does not deliver.

## Interface
- `PORT_ID`, 1: index (0–3) of the switch port this sink is attached to.
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `CNT_W`, 16: width of each statistics counter.

- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `sw_valid`  in  1  switch output valid, one cycle per packet (`valid_out`).
- `sw_source`  in  4  one-hot source port (`source_out`).
- `sw_target`  in  4  one-hot or multi-hot target mask (`target_out`).
- `sw_data`  in  8  payload (`data_out`).
- `pkt_valid`  out  1  FIFO head valid.
- `pkt_ready`  in  1  consumer accepts the head.
- `pkt_source`  out  4  head source.
- `pkt_data`  out  8  head payload.
- `fifo_level`  out  $clog2(DEPTH)+1  current occupancy.
- `rx_count`  out  CNT_W  packets written into the FIFO.
- `drop_count`  out  CNT_W  packets lost to overflow.
- `misroute_count`  out  CNT_W  packets rejected by the target check.
- `overflow`  out  1  sticky flag; set on the first drop.
- `clear_stats`  in  1  synchronous clear of the counters and `overflow`.

## Operation
- Capture: on each rising edge with `sw_valid`=1, classify the packet:
  - `misroute` when `MISROUTE_CHECK_EN` is defined and `sw_target[PORT_ID]`=0.
  - otherwise `drop` when the FIFO is full and no pop occurs in the same cycle.
  - otherwise `push`.
- `sw_target` is not stored. Only source and data enter the FIFO.
- Pop: `pkt_valid && pkt_ready` at an edge removes the head.
- Full with simultaneous push and pop: both happen, no drop, level unchanged.
- Empty with push: pop is impossible that cycle.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. `fifo_level` = writes − pops.
- Counters saturate at 2^CNT_W−1 and never wrap.
- `clear_stats`=1 zeroes all three counters and `overflow`. Clear wins over an event in the same cycle, and that event is not counted. FIFO contents are unaffected.
- Reset mid-operation discards all buffered packets immediately.

## Timing
- Reset values: `pkt_valid`=0, `pkt_source`=0, `pkt_data`=0, `fifo_level`=0, all counters 0, `overflow`=0.
- Latency: a packet sampled at edge N into an empty FIFO gives `pkt_valid`=1 with its fields after edge N (visible in cycle N+1).
- The head is held stable while `pkt_valid`=1 and `pkt_ready`=0.
- After a pop, the next entry is presented in the following cycle with no bubble. `pkt_valid` drops only when the FIFO is empty.
- Statistics update at the same edge as the capture event.
- `pkt_ready` may be asserted while `pkt_valid`=0; it has no effect.

## Configuration
- `MISROUTE_CHECK_EN` defined:
  - A packet whose target mask lacks this port's bit is not buffered.
  - `misroute_count` increments for each such packet.
- Not defined:
  - Every valid packet is treated as destined here.
  - `misroute_count` is tied to 0 and carries no logic.

## Test plan
- Single packet: reset, then `sw_valid` pulse with source=4'b0001, target=4'b0010, data=8'hAA, and `pkt_ready`=1 (PORT_ID=1). Expect `pkt_valid` for exactly one cycle with data 8'hAA, source 4'b0001, and `rx_count`=1.
- Overflow: `pkt_ready`=0, 10 back-to-back packets with data 8'h00–8'h09, DEPTH=8. Expect `fifo_level`=8, `drop_count`=2, `overflow`=1. Raising `pkt_ready` then drains 8'h00–8'h07 in order on consecutive cycles.
- Full push+pop: fill to 8, then one cycle with `sw_valid`=1 and `pkt_ready`=1. Expect level 8, `drop_count` unchanged, and the new packet last out.
- Misroute, macro defined, PORT_ID=1: packet with target 4'b0100. Expect `misroute_count`=1, FIFO empty. Then target 4'b0110 is accepted, since multicast includes this port.
- Clear collision: `clear_stats` in the same cycle as a packet. Expect counters 0 and the packet still buffered.
- Reset mid-burst: `rst_n` low with 3 entries queued. Expect `pkt_valid`=0 and `fifo_level`=0 immediately, without waiting for a clock edge.
